// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker for a four-approach traffic light.
// Decodes the four lamp buses into phases 1..6 and flags illegal patterns,
// out-of-order phase changes and phases held for the wrong number of cycles.
module traffic_light_monitor #(
    parameter logic [7:0] DWELL_P1 = 8'd5,
    parameter logic [7:0] DWELL_P2 = 8'd2,
    parameter logic [7:0] DWELL_P3 = 8'd4,
    parameter logic [7:0] DWELL_P4 = 8'd2,
    parameter logic [7:0] DWELL_P5 = 8'd3,
    parameter logic [7:0] DWELL_P6 = 8'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  main_lr,
    input  logic [2:0]  side_lr,
    input  logic [2:0]  main_lr_side,
    input  logic [2:0]  main_rl_side,
    input  logic        clr_err,
    output logic [2:0]  phase,
    output logic        locked,
    output logic        pattern_err,
    output logic        seq_err,
    output logic        dwell_err,
    output logic [2:0]  err_sticky,
    output logic [15:0] cycle_cnt
);

    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b001;

    typedef enum logic {UNSYNC, TRACK} state_t;

    state_t      state_q, state_d;
    logic [2:0]  phase_q, phase_d;
    logic [7:0]  run_q, run_d;
    logic        pattern_err_q, pattern_err_d;
    logic        seq_err_q, seq_err_d;
    logic        dwell_err_q, dwell_err_d;
    logic [2:0]  err_sticky_q, err_sticky_d;
    logic [15:0] cycle_cnt_q, cycle_cnt_d;

    logic [2:0]  dec_phase;
    logic [2:0]  exp_phase;
    logic [7:0]  run_inc;
    logic [7:0]  dwell_req;

    // Map the lamp combination (main_lr, main_rl_side, main_lr_side, side_lr)
    // to a phase number; 0 marks anything that is not one of the six phases.
    always_comb begin
        dec_phase = 3'd0;
        case ({main_lr, main_rl_side, main_lr_side, side_lr})
            {LG, LG, LR, LR}: dec_phase = 3'd1;
            {LG, LY, LR, LR}: dec_phase = 3'd2;
            {LG, LR, LG, LR}: dec_phase = 3'd3;
            {LY, LR, LY, LR}: dec_phase = 3'd4;
            {LR, LR, LR, LG}: dec_phase = 3'd5;
            {LR, LR, LR, LY}: dec_phase = 3'd6;
            default:          dec_phase = 3'd0;
        endcase
    end

    // Required dwell of the phase being left.
    always_comb begin
        dwell_req = 8'd0;
        case (phase_q)
            3'd1:    dwell_req = DWELL_P1;
            3'd2:    dwell_req = DWELL_P2;
            3'd3:    dwell_req = DWELL_P3;
            3'd4:    dwell_req = DWELL_P4;
            3'd5:    dwell_req = DWELL_P5;
            3'd6:    dwell_req = DWELL_P6;
            default: dwell_req = 8'd0;
        endcase
    end

    assign exp_phase = (phase_q == 3'd6) ? 3'd1 : 3'(phase_q + 3'd1);
    assign run_inc   = (run_q == 8'hFF) ? run_q : 8'(run_q + 8'd1);

    // Next-state: sync/track FSM, run counter, error pulses, wrap counter.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        run_d         = run_q;
        pattern_err_d = 1'b0;
        seq_err_d     = 1'b0;
        dwell_err_d   = 1'b0;
        cycle_cnt_d   = cycle_cnt_q;
        if (dec_phase == 3'd0) begin
            pattern_err_d = 1'b1;
            phase_d       = 3'd0;
            run_d         = 8'd0;
            state_d       = UNSYNC;
        end else if (dec_phase == phase_q) begin
            run_d = run_inc;
        end else begin
            // Entry from UNSYNC is unchecked: the first phase may be partial.
            phase_d = dec_phase;
            run_d   = 8'd1;
            state_d = TRACK;
            if (state_q == TRACK) begin
                seq_err_d   = (dec_phase != exp_phase);
                dwell_err_d = (run_q != dwell_req);
                if (phase_q == 3'd6 && dec_phase == 3'd1 && run_q == dwell_req)
                    cycle_cnt_d = 16'(cycle_cnt_q + 16'd1);
            end
        end
        // A new error on the same edge as clr_err keeps its bit set.
        err_sticky_d = (clr_err ? 3'b000 : err_sticky_q)
                     | {dwell_err_d, seq_err_d, pattern_err_d};
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= UNSYNC;
            phase_q       <= 3'd0;
            run_q         <= 8'd0;
            pattern_err_q <= 1'b0;
            seq_err_q     <= 1'b0;
            dwell_err_q   <= 1'b0;
            err_sticky_q  <= 3'b000;
            cycle_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            run_q         <= run_d;
            pattern_err_q <= pattern_err_d;
            seq_err_q     <= seq_err_d;
            dwell_err_q   <= dwell_err_d;
            err_sticky_q  <= err_sticky_d;
            cycle_cnt_q   <= cycle_cnt_d;
        end
    end

    assign phase       = phase_q;
    assign locked      = (state_q == TRACK);
    assign pattern_err = pattern_err_q;
    assign seq_err     = seq_err_q;
    assign dwell_err   = dwell_err_q;
    assign err_sticky  = err_sticky_q;
    assign cycle_cnt   = cycle_cnt_q;

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker for the four-approach traffic light interface. It samples the four 3-bit lamp buses each clock and decodes them into a phase number 1–6. It then checks three things: that every lamp pattern is legal, that phases follow the fixed 1→2→3→4→5→6→1 order, and that each phase lasts its programmed number of cycles. It sits beside the light controller on the same clock, drives nothing back into it, and exposes status, error pulses, sticky error flags and a completed-cycle count for the bench and for on-chip supervision.

## Interface
Parameters:
- DWELL_P1, 5: required cycles in phase 1 (8-bit value).
- DWELL_P2, 2: required cycles in phase 2.
- DWELL_P3, 4: required cycles in phase 3.
- DWELL_P4, 2: required cycles in phase 4.
- DWELL_P5, 3: required cycles in phase 5.
- DWELL_P6, 2: required cycles in phase 6.

Ports:
- clk  in  1  sole clock; all logic samples on the rising edge.
- reset  in  1  asynchronous, active-high.
- main_lr  in  3  lamp bus; 3'b100 red, 3'b010 yellow, 3'b001 green.
- side_lr  in  3  lamp bus, same encoding.
- main_lr_side  in  3  lamp bus, same encoding.
- main_rl_side  in  3  lamp bus, same encoding.
- clr_err  in  1  synchronous clear of err_sticky.
- phase  out  3  registered decoded phase; 0 = illegal pattern or no phase yet.
- locked  out  1  high while tracking a legal sequence.
- pattern_err  out  1  one-cycle pulse: illegal pattern sampled.
- seq_err  out  1  one-cycle pulse: out-of-order phase change.
- dwell_err  out  1  one-cycle pulse: phase ended with the wrong length.
- err_sticky  out  3  sticky flags {dwell, seq, pattern}.
- cycle_cnt  out  16  number of clean 6→1 wraps; wraps at 0xFFFF→0.

## Operation
- Each legal phase is one lamp pattern, given as (main_lr, main_rl_side, main_lr_side, side_lr):
  - P1: G, G, R, R.
  - P2: G, Y, R, R.
  - P3: G, R, G, R.
  - P4: Y, R, Y, R.
  - P5: R, R, R, G.
  - P6: R, R, R, Y.
- Any other combination is illegal, including 3'b000 and any non-one-hot lamp value.
- Internal state:
  - FSM with two states, UNSYNC and TRACK.
  - stored phase register (drives `phase`).
  - 8-bit run counter, saturating at 255.
- UNSYNC (the reset state):
  - Illegal pattern sampled: pattern_err pulses and phase←0.
  - Legal pattern equal to the stored phase: run count increments.
  - Legal pattern different from the stored phase: phase←new, run←1, go to TRACK. No sequence or dwell check on this entry edge, because the first phase may have been observed only partially.
- TRACK:
  - Same phase as stored: run count increments.
  - Legal different phase: check the change, then phase←new and run←1.
    - seq_err pulses if the new phase ≠ (old phase mod 6)+1.
    - dwell_err pulses if run ≠ DWELL_P(old).
    - Both may pulse on the same edge.
  - Illegal pattern: pattern_err pulses, phase←0, run←0, go to UNSYNC.
- Counting and flags:
  - cycle_cnt increments on a TRACK 6→1 change only when neither seq_err nor dwell_err fires on that edge.
  - Every error pulse sets its err_sticky bit.
  - clr_err clears all sticky bits. If clr_err and a new error occur on the same edge, the set wins for that bit.
- locked = (state == TRACK).

## Timing
- Reset values (asynchronous):
  - phase=0, locked=0, all error pulses 0, err_sticky=0, cycle_cnt=0.
  - run=0, state UNSYNC.
- Latency:
  - All outputs are registered.
  - A lamp-pattern change present before edge k shows on phase, locked and the error pulses right after edge k.
- Pulses last exactly one cycle unless the triggering condition is re-evaluated true on the next edge. A held illegal pattern therefore pulses pattern_err every cycle.
- Run length equals the number of edges at which the phase was sampled. A controller holding phase 1 for 5 clocks gives run=5 at the change edge.
- Run counter saturation: at 255 the counter holds. A phase longer than 255 cycles flags dwell_err unless its DWELL value is 255.
- Reset asserted mid-operation clears everything immediately. After release, the first change into a legal phase re-locks without any check.

## Test plan
- Nominal sequence: reset, then drive three full cycles with dwells 5,2,4,2,3,2.
  - locked rises at the first change; no error pulses.
  - cycle_cnt goes 0→1→2 (the first partial cycle ends in a clean 6→1).
  - phase steps 1..6 one edge after each change.
- Phase skip: in TRACK, go P1→P3.
  - seq_err pulses once; err_sticky=3'b010.
  - locked stays 1; phase=3.
- Dwell mismatch: hold P1 for 4 cycles, then P2.
  - dwell_err pulses; err_sticky[2]=1; seq_err stays 0.
  - A wrong 6→1 dwell leaves cycle_cnt unchanged.
- Illegal pattern: drive all four buses to 3'b001 for 2 cycles.
  - pattern_err high for 2 cycles; phase=0; locked=0.
  - Resume P3 → locked=1 with no seq_err or dwell_err.
- clr_err priority: assert clr_err on the same edge as a seq_err event → err_sticky[1]=1. Assert clr_err alone on the next edge → err_sticky=0.
- Reset mid-cycle: assert reset during P4 → all outputs 0 immediately. Release and resume at P5 → first change re-locks, no errors.
